// File: rtl/jk_counter_pkg.sv
// rtl/jk_counter_pkg.sv - mode encoding shared by the jk_counter slice
package jk_counter_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

endpackage

// File: rtl/jk_ff_sr.sv
// rtl/jk_ff_sr.sv - single-bit JK flip-flop with synchronous active-high reset to 0
module jk_ff_sr (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_counter.sv
// rtl/jk_counter.sv - modulo-N up/down/load counter on JK cells; JK_COUNTER_SATURATE_EN selects saturation instead of wrap
module jk_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD_N = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  generate
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("jk_counter: WIDTH must be in 1..16");
    end
    if (MOD_N < 2 || MOD_N > (1 << WIDTH)) begin : g_bad_mod
      $error("jk_counter: MOD_N must be in 2..2**WIDTH");
    end
  endgenerate

  // One extra bit so MOD_N == 2**WIDTH is representable.
  localparam logic [WIDTH:0] MOD_EXT  = (WIDTH + 1)'(MOD_N);
  localparam logic [WIDTH:0] LAST_EXT = (WIDTH + 1)'(MOD_N - 1);
  localparam logic [WIDTH:0] ONE_EXT  = (WIDTH + 1)'(1);

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   nxt_ext;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             wrap_nxt;

  assign q_ext = {1'b0, q};
  assign d_ext = {1'b0, d};

  always_comb begin
    nxt_ext  = q_ext;
    wrap_nxt = 1'b0;
    if (en) begin
      case (mode)
        MODE_UP: begin
          if (q_ext == LAST_EXT) begin
`ifdef JK_COUNTER_SATURATE_EN
            nxt_ext = LAST_EXT;
`else
            nxt_ext  = '0;
            wrap_nxt = 1'b1;
`endif
          end else begin
            nxt_ext = q_ext + ONE_EXT;
          end
        end
        MODE_DOWN: begin
          if (q_ext == '0) begin
`ifdef JK_COUNTER_SATURATE_EN
            nxt_ext = '0;
`else
            nxt_ext  = LAST_EXT;
            wrap_nxt = 1'b1;
`endif
          end else begin
            nxt_ext = q_ext - ONE_EXT;
          end
        end
        MODE_LOAD: begin
          nxt_ext = (d_ext < MOD_EXT) ? d_ext : LAST_EXT;
        end
        default: begin
          nxt_ext = q_ext;
        end
      endcase
    end
  end

  // The carry bit can never be set for a legal MOD_N; clamping keeps q in range regardless.
  assign nxt = nxt_ext[WIDTH] ? LAST_EXT[WIDTH-1:0] : nxt_ext[WIDTH-1:0];

  assign j = nxt & ~q;
  assign k = ~nxt & q;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_ff_sr u_cell (
        .clk (clk),
        .rst (rst),
        .j   (j[i]),
        .k   (k[i]),
        .q   (q[i])
      );
    end
  endgenerate

  assign tc = en && (((mode == MODE_UP) && (q_ext == LAST_EXT)) ||
                     ((mode == MODE_DOWN) && (q_ext == '0)));

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_nxt;
    end
  end

endmodule
